// File: rtl/sram_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_ctrl_if : CPU-side request/acknowledge bus of the SRAM controller. Rev 1.0
// -----------------------------------------------------------------------------
interface sram_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              ack;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
  );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_ctrl : single-port async SRAM controller, programmable wait states. Rev 1.0
// -----------------------------------------------------------------------------
module sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic              clk_cpu,
  input  wire logic              reset,
  sram_ctrl_if.slave             cpu,
  output logic      [ADDR_W-1:0] sram_addr,
  output logic      [15:0]       sram_dq_out,
  output logic                   sram_dq_oe,
  input  wire logic [15:0]       sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_lb_n,
  output logic                   sram_ub_n
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  // Reads count WAIT_CYCLES..0 (W+1 strobe cycles); write pulses count W-1..0.
  localparam logic [3:0] c_rd_load = 4'(WAIT_CYCLES);
  localparam logic [3:0] c_wr_load = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [15:0]       r_dout;
  logic [15:0]       w_dout_nxt;
  logic [15:0]       r_rdata;
  logic [15:0]       w_rdata_nxt;
  logic              r_ack;
  logic              w_ack_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_dq_oe;
  logic              w_dq_oe_nxt;
  logic              r_ce_n;
  logic              w_ce_n_nxt;
  logic              r_oe_n;
  logic              w_oe_n_nxt;
  logic              r_we_n;
  logic              w_we_n_nxt;
  logic              r_bs_n;
  logic              w_bs_n_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_rdata_nxt = r_rdata;
    w_ack_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cpu.req) begin
          w_addr_nxt = cpu.addr;
          w_dout_nxt = cpu.wdata;
          if (cpu.we) begin
            w_state_nxt = ST_WR_SETUP;
            w_cnt_nxt   = c_wr_load;
          end else begin
            w_state_nxt = ST_READ;
            w_cnt_nxt   = c_rd_load;
          end
        end
      end
      ST_READ: begin
        if (r_cnt == 4'd0) begin
          w_rdata_nxt = sram_dq_in;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_WR_SETUP: begin
        w_state_nxt = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_WR_HOLD: begin
        w_ack_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Pin levels are decoded from the next state so every pad is a flop output.
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_ce_n_nxt  = (w_state_nxt == ST_IDLE);
    w_bs_n_nxt  = (w_state_nxt == ST_IDLE);
    w_oe_n_nxt  = (w_state_nxt != ST_READ);
    w_we_n_nxt  = (w_state_nxt != ST_WR_PULSE);
    w_dq_oe_nxt = (w_state_nxt == ST_WR_SETUP) ||
                  (w_state_nxt == ST_WR_PULSE) ||
                  (w_state_nxt == ST_WR_HOLD);
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_dout  <= 16'h0000;
      r_rdata <= 16'h0000;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_bs_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_rdata <= w_rdata_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_dq_oe <= w_dq_oe_nxt;
      r_ce_n  <= w_ce_n_nxt;
      r_oe_n  <= w_oe_n_nxt;
      r_we_n  <= w_we_n_nxt;
      r_bs_n  <= w_bs_n_nxt;
    end
  end

  assign cpu.rdata   = r_rdata;
  assign cpu.ack     = r_ack;
  assign cpu.busy    = r_busy;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dout;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_lb_n   = r_bs_n;
  assign sram_ub_n   = r_bs_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sram_ctrl : directed bench, unit A runs W=1, unit B runs W=2 with SRAM model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   overlap_cnt;

  sram_ctrl_if #(.ADDR_W(18)) ifa ();
  sram_ctrl_if #(.ADDR_W(18)) ifb ();

  logic [17:0] a_sram_addr, b_sram_addr;
  logic [15:0] a_dq_out, b_dq_out, a_dq_in, b_dq_in;
  logic        a_dq_oe, a_ce_n, a_oe_n, a_we_n, a_lb_n, a_ub_n;
  logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n;
  logic        b_we_n_q;
  logic [15:0] memb [int];

  sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(1)) u_dut_a (
    .clk_cpu(clk), .reset(reset), .cpu(ifa),
    .sram_addr(a_sram_addr), .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe),
    .sram_dq_in(a_dq_in), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
    .sram_we_n(a_we_n), .sram_lb_n(a_lb_n), .sram_ub_n(a_ub_n)
  );

  sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(2)) u_dut_b (
    .clk_cpu(clk), .reset(reset), .cpu(ifb),
    .sram_addr(b_sram_addr), .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe),
    .sram_dq_in(b_dq_in), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
    .sram_we_n(b_we_n), .sram_lb_n(b_lb_n), .sram_ub_n(b_ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model for unit B: store on the rising edge of we_n, drive data while oe_n is low.
  always @(negedge clk) begin
    if (!b_we_n_q && b_we_n && !b_ce_n)
      memb[int'(b_sram_addr)] = b_dq_out;
    b_we_n_q = b_we_n;
    if (!b_ce_n && !b_oe_n && memb.exists(int'(b_sram_addr)))
      b_dq_in = memb[int'(b_sram_addr)];
    else
      b_dq_in = 16'h0000;
    if ((!a_oe_n && a_dq_oe) || (!b_oe_n && b_dq_oe))
      overlap_cnt++;
  end

  task automatic test_reset;
    logic [57:0] obs;
    logic [57:0] exp_v;
    exp_v = {1'b0, 1'b0, 16'h0000, 18'h0, 16'h0000, 1'b0, 5'b11111};
    reset = 1'b1;
    ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = 18'h00100; ifa.wdata = 16'h0000;
    ifb.req = 1'b1; ifb.we = 1'b1; ifb.addr = 18'h00010; ifb.wdata = 16'h1111;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      obs = {ifa.ack, ifa.busy, ifa.rdata, a_sram_addr, a_dq_out, a_dq_oe,
             a_ce_n, a_oe_n, a_we_n, a_lb_n, a_ub_n};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_a[%0d]: got %h expected %h", k, obs, exp_v);
      end
      obs = {ifb.ack, ifb.busy, ifb.rdata, b_sram_addr, b_dq_out, b_dq_oe,
             b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_b[%0d]: got %h expected %h", k, obs, exp_v);
      end
    end
    reset = 1'b0;
    ifb.req = 1'b0;
    a_dq_in = 16'h1357;
    @(posedge clk); #1;
    ifa.req = 1'b0;
    n_cmp++;
    if ({ifa.busy, a_oe_n, a_sram_addr} !== {1'b1, 1'b0, 18'h00100}) begin
      n_err++;
      $display("FAIL reset_release_accept: got busy=%b oe_n=%b addr=%h expected 1 0 00100",
               ifa.busy, a_oe_n, a_sram_addr);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_read;
    logic exp_oe_n;
    logic exp_ack;
    a_dq_in = 16'hBEEF;
    ifa.we = 1'b0; ifa.addr = 18'h00100; ifa.req = 1'b1;
    @(posedge clk); #1;
    ifa.req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_oe_n = (k >= 2);
      exp_ack  = (k == 2);
      n_cmp++;
      if ({a_oe_n, ifa.ack, a_we_n, a_dq_oe} !== {exp_oe_n, exp_ack, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL read_w1[%0d]: got oe_n=%b ack=%b we_n=%b dq_oe=%b expected %b %b 1 0",
                 k, a_oe_n, ifa.ack, a_we_n, a_dq_oe, exp_oe_n, exp_ack);
      end
      if (k == 2) begin
        n_cmp++;
        if (ifa.rdata !== 16'hBEEF) begin
          n_err++;
          $display("FAIL read_w1_rdata: got %h expected beef", ifa.rdata);
        end
      end
    end
  endtask

  task automatic test_write;
    logic exp_oe;
    logic exp_we_n;
    logic [15:0] got;
    ifb.we = 1'b1; ifb.addr = 18'h01234; ifb.wdata = 16'hA55A; ifb.req = 1'b1;
    @(posedge clk); #1;
    ifb.req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_oe   = (k < 4);
      exp_we_n = !(k == 1 || k == 2);
      n_cmp++;
      if ({b_dq_oe, b_we_n, b_ce_n, b_oe_n, ifb.ack, ifb.busy} !==
          {exp_oe, exp_we_n, !exp_oe, 1'b1, (k == 4), exp_oe}) begin
        n_err++;
        $display("FAIL write_w2[%0d]: got oe=%b we_n=%b ce_n=%b oe_n=%b ack=%b busy=%b expected %b %b %b 1 %b %b",
                 k, b_dq_oe, b_we_n, b_ce_n, b_oe_n, ifb.ack, ifb.busy,
                 exp_oe, exp_we_n, !exp_oe, (k == 4), exp_oe);
      end
      if (k < 4) begin
        n_cmp++;
        if ({b_dq_out, b_sram_addr} !== {16'hA55A, 18'h01234}) begin
          n_err++;
          $display("FAIL write_w2_data[%0d]: got %h/%h expected a55a/01234",
                   k, b_dq_out, b_sram_addr);
        end
      end
    end
    got = memb.exists(32'h1234) ? memb[32'h1234] : 16'hxxxx;
    n_cmp++;
    if (got !== 16'hA55A) begin
      n_err++;
      $display("FAIL write_w2_stored: got %h expected a55a", got);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_busy;
    int   ov0;
    ov0 = overlap_cnt;
    ifb.we = 1'b1; ifb.addr = 18'h3FFFF; ifb.wdata = 16'h5A5A; ifb.req = 1'b1;
    @(posedge clk); #1;
    ifb.we = 1'b0; ifb.wdata = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_busy = (k < 4) || (k >= 5 && k < 8);
      n_cmp++;
      if ({ifb.busy, ifb.ack, b_oe_n, b_dq_oe} !==
          {exp_busy, (k == 4 || k == 8), !(k >= 5 && k < 8), (k < 4)}) begin
        n_err++;
        $display("FAIL b2b[%0d]: got busy=%b ack=%b oe_n=%b dq_oe=%b", k, ifb.busy,
                 ifb.ack, b_oe_n, b_dq_oe);
      end
      if (k == 5) ifb.req = 1'b0;
      if (k == 8) begin
        n_cmp++;
        if (ifb.rdata !== 16'h5A5A) begin
          n_err++;
          $display("FAIL b2b_rdata: got %h expected 5a5a", ifb.rdata);
        end
      end
    end
    n_cmp++;
    if (overlap_cnt !== ov0) begin
      n_err++;
      $display("FAIL b2b_contention: got %0d overlapping cycles expected 0", overlap_cnt - ov0);
    end
  endtask

  task automatic test_reset_mid_write;
    ifb.we = 1'b1; ifb.addr = 18'h00200; ifb.wdata = 16'h1234; ifb.req = 1'b1;
    @(posedge clk); #1;
    ifb.req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b_we_n !== 1'b0) begin
      n_err++;
      $display("FAIL midwr_pulse: got we_n=%b expected 0", b_we_n);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({b_we_n, b_dq_oe, b_ce_n, ifb.busy, ifb.ack, ifb.rdata, ifa.rdata} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      n_err++;
      $display("FAIL midwr_abort: got we_n=%b dq_oe=%b ce_n=%b busy=%b ack=%b rdata=%h/%h",
               b_we_n, b_dq_oe, b_ce_n, ifb.busy, ifb.ack, ifb.rdata, ifa.rdata);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({ifb.ack, ifb.busy} !== 2'b00) begin
        n_err++;
        $display("FAIL midwr_no_ack[%0d]: got ack=%b busy=%b expected 0 0", k, ifb.ack, ifb.busy);
      end
    end
  endtask

  task automatic test_req_while_busy;
    int acks;
    acks = 0;
    a_dq_in = 16'hBEEF;
    ifa.we = 1'b0; ifa.addr = 18'h00100; ifa.req = 1'b1;
    @(posedge clk); #1;
    ifa.req = 1'b0;
    ifa.addr = 18'h00001;
    ifa.req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 1) ifa.req = 1'b0;
      if (ifa.ack) acks++;
      if (k <= 2) begin
        n_cmp++;
        if (a_sram_addr !== 18'h00100) begin
          n_err++;
          $display("FAIL busy_req_addr[%0d]: got %h expected 00100", k, a_sram_addr);
        end
      end
    end
    n_cmp++;
    if ({acks, ifa.busy, ifa.rdata} !== {32'd1, 1'b0, 16'hBEEF}) begin
      n_err++;
      $display("FAIL busy_req_acks: got acks=%0d busy=%b rdata=%h expected 1 0 beef",
               acks, ifa.busy, ifa.rdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    overlap_cnt = 0;
    b_we_n_q = 1'b1;
    b_dq_in = 16'h0000;
    a_dq_in = 16'h0000;
    reset = 1'b1;
    ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid_write();
    test_req_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
